// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared constants and state encoding for the FIFO write arbiter
package fifo_wr_arbiter_pkg;

  localparam int DATA_W            = 8;
  localparam int BEAT_W            = 4;
  localparam int MAX_BURST_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester, FIFO write and status signals of the write arbiter
interface fifo_wr_arbiter_if #(
  parameter int CNT_W = 16
);
  import fifo_wr_arbiter_pkg::*;

  logic              req0;
  logic [DATA_W-1:0] data0;
  logic              gnt0;
  logic              req1;
  logic [DATA_W-1:0] data1;
  logic              gnt1;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;
  logic              last_gnt;

  // Arbiter side.
  modport slave (
    input  req0, data0, req1, data1, fifo_full,
    output gnt0, gnt1, fifo_wr_en, fifo_wr_data, cnt0, cnt1, last_gnt
  );

  // Requesters, FIFO and observers.
  modport master (
    output req0, data0, req1, data1, fifo_full,
    input  gnt0, gnt1, fifo_wr_en, fifo_wr_data, cnt0, cnt1, last_gnt
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port between two requesters
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  // Beat counter value of the final beat of a burst.
  localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;
  logic              last_q,  last_d;
  logic [CNT_W-1:0]  cnt0_q,  cnt0_d;
  logic [CNT_W-1:0]  cnt1_q,  cnt1_d;

  logic              acc0;
  logic              acc1;

  // Reset cycle accepts nothing so an aborted burst never leaks a beat.
  assign acc0 = (state_q == OWN0) & bus.req0 & ~bus.fifo_full & ~rst;
  assign acc1 = (state_q == OWN1) & bus.req1 & ~bus.fifo_full & ~rst;

  // State register plus burst, round-robin and beat-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  // Next-state: grant selection, burst limiting and handover; a full FIFO freezes everything.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q + CNT_W'(acc0);
    cnt1_d  = cnt1_q + CNT_W'(acc1);
    case (state_q)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last_q)) begin
          state_d = OWN0;
          beat_d  = '0;
          last_d  = 1'b0;
        end else if (bus.req1) begin
          state_d = OWN1;
          beat_d  = '0;
          last_d  = 1'b1;
        end
      end
      OWN0: begin
        if (!bus.fifo_full) begin
          if (!bus.req0) begin
            if (bus.req1) begin
              state_d = OWN1;
              beat_d  = '0;
              last_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (beat_q == BURST_LAST) begin
            beat_d = '0;
            if (bus.req1) begin
              state_d = OWN1;
              last_d  = 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      OWN1: begin
        if (!bus.fifo_full) begin
          if (!bus.req1) begin
            if (bus.req0) begin
              state_d = OWN0;
              beat_d  = '0;
              last_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else if (beat_q == BURST_LAST) begin
            beat_d = '0;
            if (bus.req0) begin
              state_d = OWN0;
              last_d  = 1'b0;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Outputs: grants from registered state, zero-latency write path muxed from the owner.
  always_comb begin
    bus.gnt0         = (state_q == OWN0);
    bus.gnt1         = (state_q == OWN1);
    bus.fifo_wr_en   = acc0 | acc1;
    bus.fifo_wr_data = '0;
    if (acc0) begin
      bus.fifo_wr_data = bus.data0;
    end else if (acc1) begin
      bus.fifo_wr_data = bus.data1;
    end
    bus.cnt0     = cnt0_q;
    bus.cnt1     = cnt1_q;
    bus.last_gnt = last_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int MB   = 4;
  localparam int CW   = 16;
  localparam int CW_S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.CNT_W(CW))   bus ();
  fifo_wr_arbiter_if #(.CNT_W(CW_S)) bus_w ();

  fifo_wr_arbiter #(.MAX_BURST(MB), .CNT_W(CW))   dut   (.clk(clk), .rst(rst), .bus(bus));
  fifo_wr_arbiter #(.MAX_BURST(MB), .CNT_W(CW_S)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner -1 means nobody holds the write port.
  int  m_own   = -1;
  int  m_beats = 0;
  int  m_last  = 1;
  int  m_c0    = 0;
  int  m_c1    = 0;
  bit  m_valid = 0;
  logic [7:0] acc_log[$];

  bit         w_req1  = 0;
  logic [7:0] w_data1 = 8'h00;

  typedef struct {
    bit rst_v; bit r0; bit r1; bit full;
    logic [7:0] d0; logic [7:0] d1;
    bit g0; bit g1; bit we; logic [7:0] wd;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst_v, input bit r0, input bit r1, input bit full_v,
                      input logic [7:0] d0, input logic [7:0] d1);
    bit         rq[2];
    logic [7:0] dd[2];
    bit         acc;
    logic [7:0] exp_data;
    int         oth;
    @(negedge clk);
    rst           = rst_v;
    bus.req0      = r0;
    bus.req1      = r1;
    bus.data0     = d0;
    bus.data1     = d1;
    bus.fifo_full = full_v;
    bus_w.req0      = 1'b0;
    bus_w.data0     = 8'h00;
    bus_w.req1      = w_req1;
    bus_w.data1     = w_data1;
    bus_w.fifo_full = 1'b0;
    #1;
    rq[0] = r0; rq[1] = r1; dd[0] = d0; dd[1] = d1;
    acc      = !rst_v && (m_own >= 0) && rq[m_own < 0 ? 0 : m_own] && !full_v;
    exp_data = acc ? dd[m_own] : 8'h00;
    check("wr_en", bus.fifo_wr_en, acc);
    check("wr_data", bus.fifo_wr_data, exp_data);
    if (m_valid) begin
      check("gnt0", bus.gnt0, m_own == 0);
      check("gnt1", bus.gnt1, m_own == 1);
      check("cnt0", bus.cnt0, m_c0);
      check("cnt1", bus.cnt1, m_c1);
      check("last_gnt", bus.last_gnt, m_last);
    end
    if (rst_v) begin
      m_own = -1; m_beats = 0; m_last = 1; m_c0 = 0; m_c1 = 0; m_valid = 1;
    end else if (m_own < 0) begin
      if (r0 || r1) begin
        m_own   = (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
        m_beats = 0;
        m_last  = m_own;
      end
    end else if (!full_v) begin
      oth = 1 - m_own;
      if (!rq[m_own]) begin
        if (rq[oth]) begin
          m_own = oth; m_last = oth; m_beats = 0;
        end else begin
          m_own = -1;
        end
      end else begin
        if (m_own == 0) m_c0 = (m_c0 + 1) & ((1 << CW) - 1);
        else            m_c1 = (m_c1 + 1) & ((1 << CW) - 1);
        acc_log.push_back(dd[m_own]);
        m_beats++;
        if (m_beats == MB) begin
          m_beats = 0;
          if (rq[oth]) begin
            m_own = oth; m_last = oth;
          end
        end
      end
    end
  endtask

  task automatic reset_dut();
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    int          writes;
    bit          g1_seen;
    int          nbeat;
    bit          r0s, r1s;
    logic [7:0]  d0s, d1s;
    bit          full;
    logic [7:0]  fifo_q[$];
    logic [7:0]  rd_q[$];

    bus.req0 = 0; bus.req1 = 0; bus.data0 = 0; bus.data1 = 0; bus.fifo_full = 0;
    bus_w.req0 = 0; bus_w.req1 = 0; bus_w.data0 = 0; bus_w.data1 = 0; bus_w.fifo_full = 0;

    // Directed vector table starting right after reset (last_gnt = 1).
    tbl[0]  = '{0, 1, 1, 0, 8'hA1, 8'hB1, 0, 0, 0, 8'h00};
    tbl[1]  = '{0, 1, 1, 0, 8'hA1, 8'hB1, 1, 0, 1, 8'hA1};
    tbl[2]  = '{0, 1, 1, 1, 8'hA1, 8'hB1, 1, 0, 0, 8'h00};
    tbl[3]  = '{0, 1, 1, 0, 8'hA1, 8'hB1, 1, 0, 1, 8'hA1};
    tbl[4]  = '{0, 0, 1, 0, 8'h00, 8'hB1, 1, 0, 0, 8'h00};
    tbl[5]  = '{0, 0, 1, 0, 8'h00, 8'hB1, 0, 1, 1, 8'hB1};
    tbl[6]  = '{0, 1, 1, 0, 8'hA2, 8'hB1, 0, 1, 1, 8'hB1};
    tbl[7]  = '{0, 1, 0, 0, 8'hA2, 8'h00, 0, 1, 0, 8'h00};
    tbl[8]  = '{0, 1, 0, 0, 8'hA2, 8'h00, 1, 0, 1, 8'hA2};
    tbl[9]  = '{1, 1, 0, 0, 8'hA2, 8'h00, 1, 0, 0, 8'h00};
    tbl[10] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00};
    tbl[11] = '{0, 0, 1, 0, 8'h00, 8'hB2, 0, 0, 0, 8'h00};
    tbl[12] = '{0, 0, 1, 0, 8'h00, 8'hB2, 0, 1, 1, 8'hB2};

    reset_dut();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst_v, tbl[i].r0, tbl[i].r1, tbl[i].full, tbl[i].d0, tbl[i].d1);
      check($sformatf("tbl%0d_gnt0", i), bus.gnt0, tbl[i].g0);
      check($sformatf("tbl%0d_gnt1", i), bus.gnt1, tbl[i].g1);
      check($sformatf("tbl%0d_wr_en", i), bus.fifo_wr_en, tbl[i].we);
      check($sformatf("tbl%0d_wr_data", i), bus.fifo_wr_data, tbl[i].wd);
    end

    // Requester 0 alone: one arbitration cycle, then 10 back-to-back writes.
    reset_dut();
    writes = 0; g1_seen = 0;
    for (int i = 0; i < 11; i++) begin
      step(0, 1, 0, 0, 8'h5A, 8'h00);
      if (bus.fifo_wr_en && bus.fifo_wr_data == 8'h5A) writes++;
      if (bus.gnt1) g1_seen = 1;
    end
    check("solo_writes", writes, 10);
    check("solo_gnt1_seen", g1_seen, 0);
    step(0, 0, 0, 0, 8'h00, 8'h00);
    check("solo_cnt0", bus.cnt0, 10);

    // Both requesting from reset: owner sequence 0000 1111 0000 1111.
    reset_dut();
    nbeat = 0;
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 1, 0, 8'h0A, 8'h0B);
      if (bus.fifo_wr_en) begin
        check($sformatf("rr_beat%0d_owner", nbeat), bus.gnt1, (nbeat / MB) % 2);
        nbeat++;
      end
    end
    check("rr_beats", nbeat, 16);

    // Backpressure for 5 cycles after the first beat of a burst.
    reset_dut();
    step(0, 1, 1, 0, 8'h11, 8'h22);
    step(0, 1, 1, 0, 8'h11, 8'h22);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 1, 8'h11, 8'h22);
      check("full_wr_en", bus.fifo_wr_en, 0);
      check("full_gnt0", bus.gnt0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 8'h11, 8'h22);
      check("resume_wr", {bus.gnt0, bus.fifo_wr_en, bus.fifo_wr_data}, {2'b11, 8'h11});
    end
    step(0, 1, 1, 0, 8'h11, 8'h22);
    check("resume_handover", {bus.gnt1, bus.fifo_wr_en, bus.fifo_wr_data}, {2'b11, 8'h22});

    // Reset at beat 2 of an OWN1 burst, then a tie goes to requester 0.
    reset_dut();
    step(0, 0, 1, 0, 8'h00, 8'h77);
    step(0, 0, 1, 0, 8'h00, 8'h77);
    step(1, 1, 1, 0, 8'h66, 8'h77);
    check("rst_mid_wr_en", bus.fifo_wr_en, 0);
    step(0, 1, 1, 0, 8'h66, 8'h77);
    check("rst_mid_idle", {bus.gnt0, bus.gnt1}, 2'b00);
    check("rst_mid_cnt1", bus.cnt1, 0);
    step(0, 1, 1, 0, 8'h66, 8'h77);
    check("rst_mid_tie_gnt0", bus.gnt0, 1);

    // Narrow counter instance: 17 beats from requester 1 wrap cnt1 to 1.
    reset_dut();
    writes  = 0;
    w_req1  = 1;
    w_data1 = 8'h33;
    for (int i = 0; i < 18; i++) begin
      step(0, 0, 0, 0, 8'h00, 8'h00);
      if (bus_w.fifo_wr_en) writes++;
    end
    w_req1 = 0;
    step(0, 0, 0, 0, 8'h00, 8'h00);
    check("wrap_writes", writes, 17);
    check("wrap_cnt1", bus_w.cnt1, 1);

    // Random traffic against a 512-deep FIFO model.
    reset_dut();
    acc_log.delete();
    r0s = 0; r1s = 0; d0s = 8'h00; d1s = 8'h00;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      full = (fifo_q.size() >= 512);
      if (r0s) begin
        if ($urandom_range(3) == 0) r0s = 0;
      end else if ($urandom_range(1) == 0) begin
        r0s = 1; d0s = 8'($urandom);
      end
      if (r1s) begin
        if ($urandom_range(3) == 0) r1s = 0;
      end else if ($urandom_range(1) == 0) begin
        r1s = 1; d1s = 8'($urandom);
      end
      step(0, r0s, r1s, full, d0s, d1s);
      if (full) check("no_write_full", bus.fifo_wr_en, 0);
      if (cyc >= 800 && fifo_q.size() > 0 && $urandom_range(1) == 0) rd_q.push_back(fifo_q.pop_front());
      if (bus.fifo_wr_en && !full) fifo_q.push_back(bus.fifo_wr_data);
    end
    while (fifo_q.size() > 0) rd_q.push_back(fifo_q.pop_front());
    check("stream_len", rd_q.size(), acc_log.size());
    for (int i = 0; i < rd_q.size() && i < acc_log.size(); i++) begin
      check($sformatf("stream%0d", i), rd_q[i], acc_log[i]);
      if (rd_q[i] !== acc_log[i]) break;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
